// File: rtl/idi_pkt_rx.sv
// idi_pkt_rx: IDI receive framer. Tracks long packets against their header word count,
// buffers payload beats in a small FWFT queue with sop/eop markers and reports short
// packets, length errors, stray beats and buffer overflow as registered one-cycle pulses.
module idi_pkt_rx #(
  parameter int unsigned CSI2_HOST_IDI_CSIDATA_SIZE = 64,
  parameter int unsigned CSI2_HOST_BYTES_EN_SIZE    = 3,
  parameter int unsigned CSI2_HOST_VC_WIDTH         = 4,
  parameter int unsigned FIFO_DEPTH                 = 8
) (
  input  logic                                  clk_data,
  input  logic                                  rst_n,
  input  logic                                  header_en,
  input  logic                                  data_en,
  input  logic [CSI2_HOST_IDI_CSIDATA_SIZE-1:0] csi_data,
  input  logic [CSI2_HOST_BYTES_EN_SIZE-1:0]    byte_en,
  input  logic [5:0]                            data_type,
  input  logic [CSI2_HOST_VC_WIDTH-1:0]         virtual_channel,
  input  logic [15:0]                           world_count,
  output logic [CSI2_HOST_IDI_CSIDATA_SIZE-1:0] out_data,
  output logic [3:0]                            out_nbytes,
  output logic                                  out_sop,
  output logic                                  out_eop,
  output logic [CSI2_HOST_VC_WIDTH-1:0]         out_vc,
  output logic [5:0]                            out_dt,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  sp_valid,
  output logic [CSI2_HOST_VC_WIDTH-1:0]         sp_vc,
  output logic [5:0]                            sp_dt,
  output logic [15:0]                           sp_data,
  output logic                                  len_err,
  output logic                                  stray_err,
  output logic                                  ovf,
  output logic                                  ovf_sticky,
  input  logic                                  ovf_clr
);

  localparam int unsigned DW = CSI2_HOST_IDI_CSIDATA_SIZE;
  localparam int unsigned VW = CSI2_HOST_VC_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  // Entry layout: {data, nbytes, sop, eop, vc, dt}
  localparam int unsigned EW = DW + 4 + 2 + VW + 6;

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

  state_e          r_state, w_state_nxt;
  logic [VW-1:0]   r_cur_vc, w_vc_nxt;
  logic [5:0]      r_cur_dt, w_dt_nxt;
  logic [15:0]     r_remaining, w_rem_nxt;
  logic            r_first_beat, w_first_nxt;

  logic            w_push, w_push_sop, w_push_eop;
  logic [DW-1:0]   w_push_data;
  logic [3:0]      w_push_nbytes;
  logic            w_sp_valid, w_len_err, w_stray_err;
  logic [VW-1:0]   w_sp_vc;
  logic [5:0]      w_sp_dt;
  logic [15:0]     w_sp_data;
  logic [3:0]      w_bytes;

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic            w_empty, w_full, w_pop, w_wr, w_drop;
  logic [EW-1:0]   w_entry;

  logic            r_sp_valid, r_len_err, r_stray_err, r_ovf, r_ovf_sticky;
  logic [VW-1:0]   r_sp_vc;
  logic [5:0]      r_sp_dt;
  logic [15:0]     r_sp_data;

  assign w_bytes = 4'(byte_en) + 4'd1;

  // Framing: next state, counters, buffer push request and status pulse requests
  always_comb begin
    w_state_nxt   = r_state;
    w_vc_nxt      = r_cur_vc;
    w_dt_nxt      = r_cur_dt;
    w_rem_nxt     = r_remaining;
    w_first_nxt   = r_first_beat;
    w_push        = 1'b0;
    w_push_data   = '0;
    w_push_nbytes = 4'd0;
    w_push_sop    = 1'b0;
    w_push_eop    = 1'b0;
    w_sp_valid    = 1'b0;
    w_sp_vc       = '0;
    w_sp_dt       = '0;
    w_sp_data     = '0;
    w_len_err     = 1'b0;
    w_stray_err   = 1'b0;
    if (header_en) begin
      // A header inside a packet closes it with an empty eop marker
      if (r_state == StPayload) begin
        w_len_err   = 1'b1;
        w_push      = 1'b1;
        w_push_sop  = r_first_beat;
        w_push_eop  = 1'b1;
        w_state_nxt = StIdle;
        w_rem_nxt   = 16'd0;
      end
      if (data_en) w_stray_err = 1'b1;
      if (world_count == 16'd0) begin
        w_sp_valid = 1'b1;
        w_sp_vc    = virtual_channel;
        w_sp_dt    = data_type;
        w_sp_data  = world_count;
      end else begin
        w_vc_nxt    = virtual_channel;
        w_dt_nxt    = data_type;
        w_rem_nxt   = world_count;
        w_first_nxt = 1'b1;
        w_state_nxt = StPayload;
      end
    end else if (data_en) begin
      if (r_state == StPayload) begin
        w_push      = 1'b1;
        w_push_data = csi_data;
        w_push_sop  = r_first_beat;
        if (16'(w_bytes) < r_remaining) begin
          w_push_nbytes = w_bytes;
          w_rem_nxt     = r_remaining - 16'(w_bytes);
          w_first_nxt   = 1'b0;
        end else begin
          // remaining <= 8 here, so it fits the nbytes field
          w_push_nbytes = r_remaining[3:0];
          w_push_eop    = 1'b1;
          w_rem_nxt     = 16'd0;
          w_state_nxt   = StIdle;
          w_len_err     = (16'(w_bytes) > r_remaining);
        end
      end else begin
        w_stray_err = 1'b1;
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = out_ready & ~w_empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_entry = {w_push_data, w_push_nbytes, w_push_sop, w_push_eop, r_cur_vc, r_cur_dt};

  // Buffer storage; contents are only observed through the non-empty gate below
  always_ff @(posedge clk_data) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  // State, counters, buffer pointers and registered status pulses
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cur_vc     <= '0;
      r_cur_dt     <= '0;
      r_remaining  <= 16'd0;
      r_first_beat <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_sp_valid   <= 1'b0;
      r_sp_vc      <= '0;
      r_sp_dt      <= '0;
      r_sp_data    <= '0;
      r_len_err    <= 1'b0;
      r_stray_err  <= 1'b0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_vc     <= w_vc_nxt;
      r_cur_dt     <= w_dt_nxt;
      r_remaining  <= w_rem_nxt;
      r_first_beat <= w_first_nxt;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_sp_valid   <= w_sp_valid;
      r_sp_vc      <= w_sp_vc;
      r_sp_dt      <= w_sp_dt;
      r_sp_data    <= w_sp_data;
      r_len_err    <= w_len_err;
      r_stray_err  <= w_stray_err;
      r_ovf        <= w_drop;
      if (w_drop)       r_ovf_sticky <= 1'b1;
      else if (ovf_clr) r_ovf_sticky <= 1'b0;
    end
  end

  assign out_valid = ~w_empty;
  assign {out_data, out_nbytes, out_sop, out_eop, out_vc, out_dt} =
      w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign sp_valid   = r_sp_valid;
  assign sp_vc      = r_sp_vc;
  assign sp_dt      = r_sp_dt;
  assign sp_data    = r_sp_data;
  assign len_err    = r_len_err;
  assign stray_err  = r_stray_err;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_idi_pkt_rx.sv
// Directed testbench for idi_pkt_rx with hand-computed expectations.
module tb_idi_pkt_rx;

  logic        clk_data = 1'b0;
  logic        rst_n = 1'b0;
  logic        header_en = 1'b0, data_en = 1'b0;
  logic [63:0] csi_data = '0;
  logic [2:0]  byte_en = '0;
  logic [5:0]  data_type = '0;
  logic [3:0]  virtual_channel = '0;
  logic [15:0] world_count = '0;
  logic [63:0] out_data;
  logic [3:0]  out_nbytes;
  logic        out_sop, out_eop, out_valid;
  logic [3:0]  out_vc;
  logic [5:0]  out_dt;
  logic        out_ready = 1'b0;
  logic        sp_valid;
  logic [3:0]  sp_vc;
  logic [5:0]  sp_dt;
  logic [15:0] sp_data;
  logic        len_err, stray_err, ovf, ovf_sticky;
  logic        ovf_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_ovf    = 0;

  idi_pkt_rx #(
    .CSI2_HOST_IDI_CSIDATA_SIZE(64),
    .CSI2_HOST_BYTES_EN_SIZE   (3),
    .CSI2_HOST_VC_WIDTH        (4),
    .FIFO_DEPTH                (8)
  ) u_dut (
    .clk_data       (clk_data),
    .rst_n          (rst_n),
    .header_en      (header_en),
    .data_en        (data_en),
    .csi_data       (csi_data),
    .byte_en        (byte_en),
    .data_type      (data_type),
    .virtual_channel(virtual_channel),
    .world_count    (world_count),
    .out_data       (out_data),
    .out_nbytes     (out_nbytes),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_vc         (out_vc),
    .out_dt         (out_dt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .sp_valid       (sp_valid),
    .sp_vc          (sp_vc),
    .sp_dt          (sp_dt),
    .sp_data        (sp_data),
    .len_err        (len_err),
    .stray_err      (stray_err),
    .ovf            (ovf),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr)
  );

  always #5 clk_data = ~clk_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic hdr(input logic [3:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    virtual_channel = vc;
    data_type       = dt;
    world_count     = wc;
    header_en       = 1'b1;
    tick();
    header_en       = 1'b0;
  endtask

  task automatic beat(input logic [2:0] be, input logic [63:0] d);
    byte_en  = be;
    csi_data = d;
    data_en  = 1'b1;
    tick();
    data_en  = 1'b0;
  endtask

  task automatic check_entry(input string tag, input logic [63:0] d, input logic [3:0] nb,
                             input logic sop, input logic eop);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".data"}, out_data, d);
    check({tag, ".nbytes"}, 64'(out_nbytes), 64'(nb));
    check({tag, ".sop"}, 64'(out_sop), 64'(sop));
    check({tag, ".eop"}, 64'(out_eop), 64'(eop));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data", out_data, 64'd0);
    check("rst.out_nbytes", 64'(out_nbytes), 64'd0);
    check("rst.sop_eop", 64'({out_sop, out_eop}), 64'd0);
    check("rst.vc_dt", 64'({out_vc, out_dt}), 64'd0);
    check("rst.sp", 64'({sp_valid, sp_vc, sp_dt, sp_data}), 64'd0);
    check("rst.errs", 64'({len_err, stray_err, ovf, ovf_sticky}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Long packet WC=20: beats 8,8,4 bytes
    out_ready = 1'b1;
    hdr(4'd2, 6'h2B, 16'd20);
    check("t1.hdr.valid", 64'(out_valid), 64'd0);
    check("t1.hdr.sp", 64'(sp_valid), 64'd0);
    beat(3'd7, 64'h1111_2222_3333_4444);
    check_entry("t1.e0", 64'h1111_2222_3333_4444, 4'd8, 1'b1, 1'b0);
    check("t1.e0.vc", 64'(out_vc), 64'd2);
    check("t1.e0.dt", 64'(out_dt), 64'h2B);
    beat(3'd7, 64'h5555_6666_7777_8888);
    check_entry("t1.e1", 64'h5555_6666_7777_8888, 4'd8, 1'b0, 1'b0);
    beat(3'd3, 64'h0000_0000_9999_AAAA);
    check_entry("t1.e2", 64'h0000_0000_9999_AAAA, 4'd4, 1'b0, 1'b1);
    check("t1.errs", 64'({len_err, stray_err, ovf}), 64'd0);
    tick();
    check("t1.drained", 64'(out_valid), 64'd0);

    // WC=10 with 16 bytes supplied: truncated eop entry and one len_err pulse
    hdr(4'd1, 6'h2A, 16'd10);
    beat(3'd7, 64'hA0A0_A0A0_A0A0_A0A0);
    check_entry("t2.e0", 64'hA0A0_A0A0_A0A0_A0A0, 4'd8, 1'b1, 1'b0);
    check("t2.e0.len_err", 64'(len_err), 64'd0);
    beat(3'd7, 64'hB1B1_B1B1_B1B1_B1B1);
    check_entry("t2.e1", 64'hB1B1_B1B1_B1B1_B1B1, 4'd2, 1'b0, 1'b1);
    check("t2.len_err", 64'(len_err), 64'd1);
    tick();
    check("t2.len_err_pulse", 64'(len_err), 64'd0);
    beat(3'd7, 64'h1);
    check("t2.idle_stray", 64'(stray_err), 64'd1);
    check("t2.idle_nopush", 64'(out_valid), 64'd0);

    // WC=16 aborted by a short packet header
    hdr(4'd0, 6'h2B, 16'd16);
    beat(3'd7, 64'hC3C3_C3C3_C3C3_C3C3);
    check_entry("t3.e0", 64'hC3C3_C3C3_C3C3_C3C3, 4'd8, 1'b1, 1'b0);
    hdr(4'd3, 6'h00, 16'd0);
    check_entry("t3.marker", 64'd0, 4'd0, 1'b0, 1'b1);
    check("t3.marker.dt", 64'(out_dt), 64'h2B);
    check("t3.len_err", 64'(len_err), 64'd1);
    check("t3.sp_valid", 64'(sp_valid), 64'd1);
    check("t3.sp_fields", 64'({sp_vc, sp_dt, sp_data}), 64'({4'd3, 6'h00, 16'h0000}));
    tick();
    check("t3.pulses_end", 64'({len_err, sp_valid}), 64'd0);
    check("t3.drained", 64'(out_valid), 64'd0);

    // Overflow: 10 beats of an 80-byte packet into an 8-entry buffer, no pops
    out_ready = 1'b0;
    hdr(4'd1, 6'h1E, 16'd80);
    for (int i = 0; i < 10; i++) begin
      beat(3'd7, 64'(i + 1));
      if (ovf) n_ovf++;
      check($sformatf("t4.ovf%0d", i), 64'(ovf), (i >= 8) ? 64'd1 : 64'd0);
    end
    check("t4.ovf_count", 64'(n_ovf), 64'd2);
    tick();
    check("t4.ovf_pulse_end", 64'(ovf), 64'd0);
    check("t4.sticky", 64'(ovf_sticky), 64'd1);
    check_entry("t4.hold", 64'd1, 4'd8, 1'b1, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_entry($sformatf("t4.drain%0d", i), 64'(i + 1), 4'd8, (i == 0), 1'b0);
      tick();
    end
    check("t4.empty", 64'(out_valid), 64'd0);
    check("t4.sticky_held", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4.sticky_clr", 64'(ovf_sticky), 64'd0);

    // Stray beats: IDLE data, then header and data together
    beat(3'd3, 64'h0000_0000_DEAD_BEEF);
    check("t5.stray1", 64'(stray_err), 64'd1);
    check("t5.nopush1", 64'(out_valid), 64'd0);
    tick();
    check("t5.stray_pulse", 64'(stray_err), 64'd0);
    data_en  = 1'b1;
    csi_data = 64'h1234;
    hdr(4'd7, 6'h12, 16'd0);
    data_en  = 1'b0;
    check("t5.stray2", 64'(stray_err), 64'd1);
    check("t5.sp2", 64'({sp_valid, sp_vc, sp_dt}), 64'({1'b1, 4'd7, 6'h12}));
    check("t5.nopush2", 64'(out_valid), 64'd0);

    // Reset mid-packet, then a fresh single-beat packet
    out_ready = 1'b0;
    hdr(4'd0, 6'h2B, 16'd32);
    beat(3'd7, 64'hE1);
    beat(3'd7, 64'hE2);
    check("t6.pre_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    hdr(4'd5, 6'h12, 16'd8);
    beat(3'd7, 64'hF00D_F00D_F00D_F00D);
    check_entry("t6.e0", 64'hF00D_F00D_F00D_F00D, 4'd8, 1'b1, 1'b1);
    check("t6.vc", 64'(out_vc), 64'd5);
    check("t6.errs", 64'({len_err, stray_err, ovf}), 64'd0);
    tick();
    check("t6.drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
